// File: rtl/itch_pkg.sv
// ---------------------------------------------------------------------------
// itch_pkg
// Shared definitions for the ITCH Add-Order serializer: message length,
// byte offsets of each field within the 26-byte wire message, side
// characters, the FSM state type and the byte-selection helper.
// ---------------------------------------------------------------------------
package itch_pkg;

    localparam int unsigned MSG_BYTES = 26;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned NUM_REGS  = 7;

    // First byte of each field on the wire
    localparam int unsigned OFF_TYPE     = 0;
    localparam int unsigned OFF_TS       = 1;
    localparam int unsigned OFF_ORDER    = 5;
    localparam int unsigned OFF_SIDE     = 9;
    localparam int unsigned OFF_SHARES   = 10;
    localparam int unsigned OFF_STOCK_HI = 14;
    localparam int unsigned OFF_STOCK_LO = 18;
    localparam int unsigned OFF_PRICE    = 22;

    localparam logic [7:0] SIDE_BUY  = 8'h42;
    localparam logic [7:0] SIDE_SELL = 8'h53;

    // Element 0 holds reg_1, element 6 holds reg_7
    typedef logic [NUM_REGS-1:0][31:0] regs_t;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    // Byte k (0 = MSB) of a 32-bit big-endian field
    function automatic logic [7:0] be_byte(input logic [31:0] word, input int unsigned k);
        logic [7:0] b;
        case (k)
            0:       b = word[31:24];
            1:       b = word[23:16];
            2:       b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    // Wire byte at position idx of the message described by regs
    function automatic logic [7:0] itch_byte(input logic [IDX_W-1:0] idx, input regs_t regs);
        int unsigned i;
        logic [7:0]  b;
        i = {27'd0, idx};
        if (i < OFF_TS)
            b = regs[0][8:1];
        else if (i < OFF_ORDER)
            b = be_byte(regs[1], i - OFF_TS);
        else if (i < OFF_SIDE)
            b = be_byte(regs[2], i - OFF_ORDER);
        else if (i == OFF_SIDE)
            b = regs[0][0] ? SIDE_SELL : SIDE_BUY;
        else if (i < OFF_STOCK_HI)
            b = be_byte(regs[3], i - OFF_SHARES);
        else if (i < OFF_STOCK_LO)
            b = be_byte(regs[4], i - OFF_STOCK_HI);
        else if (i < OFF_PRICE)
            b = be_byte(regs[5], i - OFF_STOCK_LO);
        else if (i < MSG_BYTES)
            b = be_byte(regs[6], i - OFF_PRICE);
        else
            b = '0;
        return b;
    endfunction

endpackage

// File: rtl/itch_serializer_if.sv
// ---------------------------------------------------------------------------
// itch_serializer_if
// Bundles the parser-side input handshake (i_valid/o_ready + 7 registers),
// the byte-stream output (o_data/o_valid/i_ready/o_sop/o_last) and the two
// status counters. Signal names are from the serializer's point of view.
//   master : parser / stream sink side (drives i_*)
//   slave  : the serializer (drives o_*)
// ---------------------------------------------------------------------------
interface itch_serializer_if #(
    parameter int unsigned REG_WIDTH = 32,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 i_valid;
    logic                 o_ready;
    logic [REG_WIDTH-1:0] i_reg_1;
    logic [REG_WIDTH-1:0] i_reg_2;
    logic [REG_WIDTH-1:0] i_reg_3;
    logic [REG_WIDTH-1:0] i_reg_4;
    logic [REG_WIDTH-1:0] i_reg_5;
    logic [REG_WIDTH-1:0] i_reg_6;
    logic [REG_WIDTH-1:0] i_reg_7;
    logic [7:0]           o_data;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_sop;
    logic                 o_last;
    logic [CNT_WIDTH-1:0] o_msg_count;
    logic [CNT_WIDTH-1:0] o_drop_count;

    modport master (
        output i_valid, i_reg_1, i_reg_2, i_reg_3, i_reg_4, i_reg_5, i_reg_6, i_reg_7, i_ready,
        input  o_ready, o_data, o_valid, o_sop, o_last, o_msg_count, o_drop_count
    );

    modport slave (
        input  i_valid, i_reg_1, i_reg_2, i_reg_3, i_reg_4, i_reg_5, i_reg_6, i_reg_7, i_ready,
        output o_ready, o_data, o_valid, o_sop, o_last, o_msg_count, o_drop_count
    );
endinterface

// File: rtl/itch_serializer.sv
// ---------------------------------------------------------------------------
// itch_serializer
// Takes one 7-register ITCH Add-Order word set per handshake and streams it
// as a 26-byte big-endian message, one byte per cycle. One pending slot lets
// a second message queue behind the active one; inputs arriving while the
// slot is full are dropped and counted.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : itch_serializer_if.slave (input handshake, byte stream,
//             saturating message / drop counters)
// ---------------------------------------------------------------------------
module itch_serializer
    import itch_pkg::*;
#(
    parameter int unsigned REG_WIDTH = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input logic              i_clk,
    input logic              i_rst_n,
    itch_serializer_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_BYTES - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_nxt;
    regs_t                r_act;
    regs_t                w_act_nxt;
    regs_t                r_pend;
    logic                 r_pend_full;
    logic                 w_pend_full_nxt;
    logic                 w_pend_wr;
    logic                 r_valid;
    logic                 r_sop;
    logic                 r_last;
    logic [7:0]           r_data;
    logic [CNT_WIDTH-1:0] r_msg_count;
    logic [CNT_WIDTH-1:0] r_drop_count;

    logic [REG_WIDTH-1:0] w_reg [NUM_REGS];
    regs_t                w_in;
    logic                 w_accept;
    logic                 w_drop;
    logic                 w_xfer;
    logic                 w_done;
    logic                 w_out_valid;

    assign w_reg[0] = bus.i_reg_1;
    assign w_reg[1] = bus.i_reg_2;
    assign w_reg[2] = bus.i_reg_3;
    assign w_reg[3] = bus.i_reg_4;
    assign w_reg[4] = bus.i_reg_5;
    assign w_reg[5] = bus.i_reg_6;
    assign w_reg[6] = bus.i_reg_7;
    assign w_in     = {w_reg[6], w_reg[5], w_reg[4], w_reg[3], w_reg[2], w_reg[1], w_reg[0]};

    // Reads 1 while reset is held, even if the slot is still marked full
    assign bus.o_ready = !r_pend_full || !i_rst_n;

    assign w_accept = bus.i_valid && bus.o_ready;
    assign w_drop   = bus.i_valid && !bus.o_ready;
    assign w_xfer   = r_valid && bus.i_ready;
    assign w_done   = w_xfer && (r_idx == LAST_IDX);

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_act_nxt       = r_act;
        w_pend_full_nxt = r_pend_full;
        w_pend_wr       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_act_nxt   = w_in;
                    w_idx_nxt   = '0;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (w_done) begin
                    w_idx_nxt = '0;
                    if (r_pend_full) begin
                        w_act_nxt       = r_pend;
                        w_pend_full_nxt = 1'b0;
                    end else if (w_accept) begin
                        w_act_nxt = w_in;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    if (w_xfer)
                        w_idx_nxt = r_idx + 1'b1;
                    if (w_accept) begin
                        w_pend_wr       = 1'b1;
                        w_pend_full_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output byte/flags are computed from next-cycle state so they are registered
    // and appear one cycle after the accept, holding while idx does not move.
    assign w_out_valid = (w_state_nxt == SEND);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_act        <= '0;
            r_pend       <= '0;
            r_pend_full  <= 1'b0;
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_sop        <= 1'b0;
            r_last       <= 1'b0;
            r_msg_count  <= '0;
            r_drop_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_act       <= w_act_nxt;
            r_pend_full <= w_pend_full_nxt;
            if (w_pend_wr)
                r_pend <= w_in;
            r_valid <= w_out_valid;
            r_data  <= w_out_valid ? itch_byte(w_idx_nxt, w_act_nxt) : '0;
            r_sop   <= w_out_valid && (w_idx_nxt == '0);
            r_last  <= w_out_valid && (w_idx_nxt == LAST_IDX);
            if (w_done && (r_msg_count != '1))
                r_msg_count <= r_msg_count + 1'b1;
            if (w_drop && (r_drop_count != '1))
                r_drop_count <= r_drop_count + 1'b1;
        end
    end

    assign bus.o_valid      = r_valid;
    assign bus.o_data       = r_data;
    assign bus.o_sop        = r_sop;
    assign bus.o_last       = r_last;
    assign bus.o_msg_count  = r_msg_count;
    assign bus.o_drop_count = r_drop_count;

endmodule
